serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock through a single full-subtractor cell with a registered borrow.
- It is the inverse operation of the team's 4-bit ripple-carry adder, folded in time: the RCA ripples carry across N cells in space, this block ripples borrow across N cycles.
- Operands arrive over a valid/ready handshake. The result is held on a valid/ready output until it is consumed.
- Result outputs mirror the RCA's sum/cout/out set: diff, bout and packed out.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_N = 4;
    localparam int unsigned STATE_W   = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_CALC = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell, purely combinational.
// Ports:
//   a, b - minuend and subtrahend bits
//   bin  - borrow in
//   d    - difference bit
//   bo   - borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b, LSB first, one bit per clock
// through one full_subtractor cell with a registered borrow.
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   in_valid / in_ready  - operand handshake (ready only in IDLE)
//   a, b                 - unsigned minuend / subtrahend, N bits
//   out_valid / out_ready- result handshake, result held until consumed
//   diff                 - (a - b) mod 2^N
//   bout                 - final borrow (a < b)
//   out                  - {bout, diff}
//   ovf                  - signed overflow, only when SERIAL_SUB_OVF_EN is defined
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic [N:0]   out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(N);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [N-1:0]       a_sr;
    logic [N-1:0]       b_sr;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt;
    logic               d_c;
    logic               bo_c;
    logic               last_bit_c;

    full_subtractor u_fs (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (borrow_q),
        .d   (d_c),
        .bo  (bo_c)
    );

    assign last_bit_c = (cnt == CNT_W'(N - 1));
    assign out        = {bout, diff};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)   state_next = ST_CALC;
            ST_CALC: if (last_bit_c) state_next = ST_DONE;
            ST_DONE: if (out_ready)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Handshake flags are registered decodes of the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == ST_IDLE);
            out_valid <= (state_next == ST_DONE);
        end
    end

    // Datapath: operand capture, one-bit-per-cycle shift, result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            diff     <= '0;
            bout     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow_q <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ST_CALC: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    borrow_q <= bo_c;
                    cnt      <= cnt + CNT_W'(1);
                    // New bit enters at the MSB; after N steps bit 0 is the LSB result
                    diff     <= {d_c, diff[N-1:1]};
                    if (last_bit_c) begin
                        bout <= bo_c;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Overflow = borrow into MSB xor borrow out of MSB, captured on the MSB step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == ST_CALC && last_bit_c) begin
            ovf <= borrow_q ^ bo_c;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=4): directed vector table,
// multi-cycle corner sequences, and random operands checked against an
// arithmetic reference model.
module tb_serial_subtractor;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic [N:0]   out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int vectors;
    int miscompares;

    serial_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .out       (out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int exp_diff;
        int exp_bout;
        int exp_ovf;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    task automatic model(input int ia, input int ib,
                         output int ed, output int eb, output int eo);
        int dd;
        int sa;
        int sb;
        int sd;
        dd = ia - ib;
        ed = (dd + (1 << N)) % (1 << N);
        eb = (dd < 0) ? 1 : 0;
        sa = (ia >= (1 << (N - 1))) ? ia - (1 << N) : ia;
        sb = (ib >= (1 << (N - 1))) ? ib - (1 << N) : ib;
        sd = sa - sb;
        eo = (sd < -(1 << (N - 1)) || sd > (1 << (N - 1)) - 1) ? 1 : 0;
    endtask

    // One full transaction; called at a negedge, returns at a negedge in IDLE
    task automatic run_op(input int ta, input int tb_, input int ed, input int eb,
                          input int eo, input int stall, input bit junk);
        int lat;
        int waitc;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("accept_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        a = N'(ta);
        b = N'(tb_);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_in_ready", int'(in_ready), 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 4 * N) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, N);
        check("diff", int'(diff), ed);
        check("bout", int'(bout), eb);
        check("out", int'(out), eb * (1 << N) + ed);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", int'(ovf), eo);
`else
        if (eo < 0) $display("unexpected negative ovf expectation");
`endif
        for (int s = 0; s < stall; s++) begin
            if (junk) begin
                in_valid = 1'b1;
                a = N'(1);
                b = N'(0);
            end
            @(negedge clk);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_diff", int'(diff), ed);
            check("hold_bout", int'(bout), eb);
            check("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);
    endtask

    vec_t vecs[8];

    initial begin
        int ed;
        int eb;
        int eo;
        int prev;
        int hits;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;

        vecs[0] = '{6,  4,  2,  0, 0};
        vecs[1] = '{10, 14, 12, 1, 0};
        vecs[2] = '{9,  9,  0,  0, 0};
        vecs[3] = '{8,  1,  7,  0, 1};
        vecs[4] = '{0,  15, 1,  1, 0};
        vecs[5] = '{5,  7,  14, 1, 0};
        vecs[6] = '{15, 0,  15, 0, 0};
        vecs[7] = '{0,  0,  0,  0, 0};

        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
        check("rst_out", int'(out), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", int'(ovf), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_bout,
                   vecs[i].exp_ovf, 0, 1'b0);
        end

        // Stall in DONE with a competing operand presented
        run_op(9, 9, 0, 0, 0, 5, 1'b1);
        // The ignored operand (1,0) must not have been captured
        repeat (3) @(negedge clk);
        check("no_capture_out_valid", int'(out_valid), 0);
        check("no_capture_in_ready", int'(in_ready), 1);

        // Reset in the 2nd CALC cycle discards the operation
        in_valid = 1'b1;
        a = N'(7);
        b = N'(5);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_diff", int'(diff), 0);
        check("midrst_bout", int'(bout), 0);
        check("midrst_out", int'(out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N + 3; k++) begin
            @(negedge clk);
            check("midrst_no_valid", int'(out_valid), 0);
        end
        model(5, 7, ed, eb, eo);
        run_op(5, 7, ed, eb, eo, 0, 1'b0);

        // Random operands against the model
        for (int r = 0; r < 40; r++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, (1 << N) - 1));
            rb = int'($urandom_range(0, (1 << N) - 1));
            model(ra, rb, ed, eb, eo);
            run_op(ra, rb, ed, eb, eo, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // Back-to-back: one result every N+2 cycles, out_valid one cycle wide
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = N'(3);
        b = N'(1);
        prev = -1;
        hits = 0;
        for (int cyc = 0; cyc < 32; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                check("b2b_diff", int'(diff), 2);
                if (prev >= 0) check("b2b_interval", cyc - prev, N + 2);
                prev = cyc;
                hits++;
            end
        end
        check("b2b_results", hits >= 4 ? 1 : 0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
